bin_to_bcd_encoder: RTL and testbench

BIN_TO_BCD_ENCODER -- requirements
Module: bin_to_bcd_encoder

---
 rtl/bin_to_bcd_encoder.sv | 119 +++++++++++
 tb/tb_bin_to_bcd_encoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_encoder.sv
// Sequential double-dabble binary-to-BCD converter: one bit per cycle, done pulses WIDTH cycles after start.
// No backpressure: start is only taken in IDLE and ignored while busy; results saturate to all-9s above MAXVAL.
module bin_to_bcd_encoder #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int BW = 4 * DIGITS;

  function automatic logic [63:0] calc_maxval(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam logic [63:0]   MAXVAL = calc_maxval(DIGITS);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [BW-1:0] SAT    = {DIGITS{4'h9}};

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [BW-1:0]     adj;

  // Add-3 correction on every scratch digit before the shift.
  always_comb begin
    adj = scratch_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d    = bin_in;
          scratch_d  = '0;
          cnt_d      = '0;
          ovf_pend_d = (64'(bin_in) > MAXVAL);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, shift_d} = {adj, shift_q} << 1;
        cnt_d = cnt_q + 1'b1;
        // Last iteration: publish the freshly shifted scratch (or saturation).
        if (cnt_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          bcd_d   = ovf_pend_q ? SAT : scratch_d;
          ovf_d   = ovf_pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;
  assign done     = done_q;
  assign busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_bin_to_bcd_encoder.sv
// Directed bench for bin_to_bcd_encoder at default parameters (WIDTH=14, DIGITS=4).
module tb_bin_to_bcd_encoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin_in;
  logic [15:0] bcd_out;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_bcd;
  logic        prev_ovf;

  bin_to_bcd_encoder #(.WIDTH(14), .DIGITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .bcd_out  (bcd_out),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int step_val(input int i);
    return (i < 100) ? i : (i - 100) * 101;
  endfunction

  // One isolated conversion: latency, single done pulse, held outputs while busy.
  task automatic run_conv(input string tag, input logic [13:0] v,
                          input logic [15:0] exp_bcd, input logic exp_ovf);
    int cnt;
    int dn;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    bin_in = ~v;
    cnt = 0;
    dn  = 0;
    while (busy && cnt < 40) begin
      cnt++;
      if (done) dn++;
      if (cnt == 7) chk({tag, "_hold_bcd"}, 32'(bcd_out), 32'(prev_bcd));
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(cnt), 32'd14);
    chk({tag, "_done_during_busy"}, 32'(dn), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    prev_bcd = exp_bcd;
    prev_ovf = exp_ovf;
    @(negedge clk);
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cnt;
    int dn;
    int gap;
    int sampled;

    rst_n    = 1'b0;
    start    = 1'b0;
    bin_in   = '0;
    prev_bcd = 16'h0000;
    prev_ovf = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_conv("zero", 14'd0, 16'h0000, 1'b0);
    run_conv("v1234", 14'd1234, 16'h1234, 1'b0);
    run_conv("v9999", 14'd9999, 16'h9999, 1'b0);
    run_conv("v12000", 14'd12000, 16'h9999, 1'b1);
    run_conv("v16383", 14'd16383, 16'h9999, 1'b1);
    run_conv("v59", 14'd59, 16'h0059, 1'b0);

    // start re-asserted mid-conversion must be ignored
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd59;
    @(negedge clk);
    start  = 1'b0;
    cnt = 0;
    dn  = 0;
    while (busy && cnt < 40) begin
      cnt++;
      if (cnt == 5) begin start = 1'b1; bin_in = 14'd7; end
      if (cnt == 6) begin start = 1'b0; bin_in = 14'd0; end
      @(negedge clk);
    end
    chk("ign_busy_cycles", 32'(cnt), 32'd14);
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_bcd", 32'(bcd_out), 32'h0059);
    chk("ign_ovf", 32'(overflow), 32'd0);
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("ign_no_second_conv", 32'(dn), 32'd0);

    // reset in the middle of a conversion
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd4321;
    @(negedge clk);
    start  = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd", 32'(bcd_out), 32'h0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    prev_bcd = 16'h0000;
    prev_ovf = 1'b0;
    run_conv("v4321", 14'd4321, 16'h4321, 1'b0);

    // start held high, back-to-back conversions every 15 cycles
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'(step_val(0));
    for (int i = 0; i < 200; i++) begin
      sampled = step_val(i);
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!done && gap < 40);
      chk("b2b_gap", 32'(gap), 32'd15);
      chk("b2b_bcd", 32'(bcd_out), 32'(to_bcd(sampled)));
      chk("b2b_ovf", 32'(overflow), 32'd0);
      if (i < 199) bin_in = 14'(step_val(i + 1));
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
